// File: rtl/sdram_cmd_arbiter.sv
// sdram_cmd_arbiter: arbitrates SDRAM pins between init, refresh, write and read sequencers
// Refresh has priority in idle but never preempts a running burst; missed intervals raise ref_overrun.
// Define ARB_RR_EN for round-robin write/read arbitration; otherwise write always beats read.
`ifndef ASIZE
`define ASIZE 13
`endif
`ifndef BSIZE
`define BSIZE 2
`endif
module sdram_cmd_arbiter #(
    parameter int REF_PERIOD = 781
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              init_done,
    input  logic              wr_req,
    input  logic              rd_req,
    output logic              write_en,
    output logic              read_en,
    output logic              ref_en,
    input  logic              Wdata_done,
    input  logic              Rdata_done,
    input  logic              Ref_done,
    input  logic [3:0]        init_cmd,
    input  logic [3:0]        ref_cmd,
    input  logic [3:0]        wr_cmd,
    input  logic [3:0]        rd_cmd,
    input  logic [`ASIZE-1:0] init_sa,
    input  logic [`ASIZE-1:0] ref_sa,
    input  logic [`ASIZE-1:0] wr_sa,
    input  logic [`ASIZE-1:0] rd_sa,
    input  logic [`BSIZE-1:0] init_ba,
    input  logic [`BSIZE-1:0] ref_ba,
    input  logic [`BSIZE-1:0] wr_ba,
    input  logic [`BSIZE-1:0] rd_ba,
    output logic              Cs_n,
    output logic              Ras_n,
    output logic              Cas_n,
    output logic              We_n,
    output logic [`ASIZE-1:0] Sa,
    output logic [`BSIZE-1:0] Ba,
    output logic              ref_overrun
);
    typedef enum logic [2:0] {S_INIT, S_IDLE, S_AREF, S_WRITE, S_READ} state_t;
    localparam logic [15:0] LAST = 16'(REF_PERIOD - 1);
    state_t      r_state, w_next;
    logic [15:0] r_cnt;
    logic        r_seen, r_pending, r_overrun;
    logic        w_expire, w_run, w_pick_wr, w_pick_rd, w_enter_aref;
    logic [3:0]  w_cmd;
    assign w_run        = r_seen | init_done;
    assign w_expire     = (r_cnt == LAST);
    assign w_enter_aref = (r_state == S_IDLE) && r_pending;
`ifdef ARB_RR_EN
    logic r_last_wr;
    assign w_pick_wr = wr_req & (~rd_req | ~r_last_wr);
`else
    assign w_pick_wr = wr_req;
`endif
    assign w_pick_rd = rd_req & ~w_pick_wr;
    // next state: refresh first in idle, each operation runs until its own done pulse
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_INIT:  w_next = init_done ? S_IDLE : S_INIT;
            S_IDLE:  w_next = r_pending ? S_AREF : w_pick_wr ? S_WRITE : w_pick_rd ? S_READ : S_IDLE;
            S_AREF:  w_next = Ref_done ? S_IDLE : S_AREF;
            S_WRITE: w_next = Wdata_done ? S_IDLE : S_WRITE;
            S_READ:  w_next = Rdata_done ? S_IDLE : S_READ;
            default: w_next = S_INIT;
        endcase
    end
    // state register
    always_ff @(posedge Clk) begin
        if (Rst) r_state <= S_INIT;
        else     r_state <= w_next;
    end
    // refresh interval counter, pending request and sticky overrun flag
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_cnt     <= '0;
            r_seen    <= 1'b0;
            r_pending <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_seen    <= w_run;
            if (w_run) r_cnt <= w_expire ? '0 : r_cnt + 16'd1;
            r_pending <= w_expire | (r_pending & ~w_enter_aref);
            r_overrun <= r_overrun | (w_expire & r_pending);
        end
    end
`ifdef ARB_RR_EN
    // remember which requester won last so a tie goes to the other one
    always_ff @(posedge Clk) begin
        if (Rst)                                         r_last_wr <= 1'b0;
        else if (r_state == S_IDLE && w_next == S_WRITE) r_last_wr <= 1'b1;
        else if (r_state == S_IDLE && w_next == S_READ)  r_last_wr <= 1'b0;
    end
`endif
    assign ref_en      = (r_state == S_AREF);
    assign write_en    = (r_state == S_WRITE);
    assign read_en     = (r_state == S_READ);
    assign ref_overrun = r_overrun;
    // pin mux follows the state register; idle drives NOP
    always_comb begin
        w_cmd = 4'b0111;
        Sa    = '0;
        Ba    = '0;
        case (r_state)
            S_INIT:  begin w_cmd = init_cmd; Sa = init_sa; Ba = init_ba; end
            S_AREF:  begin w_cmd = ref_cmd;  Sa = ref_sa;  Ba = ref_ba;  end
            S_WRITE: begin w_cmd = wr_cmd;   Sa = wr_sa;   Ba = wr_ba;   end
            S_READ:  begin w_cmd = rd_cmd;   Sa = rd_sa;   Ba = rd_ba;   end
            default: ;
        endcase
    end
    assign {Cs_n, Ras_n, Cas_n, We_n} = w_cmd;
endmodule

// File: tb/tb_sdram_cmd_arbiter.sv
// tb_sdram_cmd_arbiter: scoreboard bench for sdram_cmd_arbiter with REF_PERIOD=100
`ifndef ASIZE
`define ASIZE 13
`endif
`ifndef BSIZE
`define BSIZE 2
`endif
module tb_sdram_cmd_arbiter;
    localparam int K_REF = 0, K_WR = 1, K_RD = 2, K_INIT = 3;
    typedef struct { int kind; int at; } exp_t;
    logic Clk = 1'b0, Rst = 1'b1, init_done = 1'b0, wr_req = 1'b0, rd_req = 1'b0;
    logic Wdata_done = 1'b0, Rdata_done = 1'b0, Ref_done = 1'b0;
    logic write_en, read_en, ref_en, Cs_n, Ras_n, Cas_n, We_n, ref_overrun;
    logic [3:0] init_cmd = 4'b0010, ref_cmd = 4'b0001, wr_cmd = 4'b0100, rd_cmd = 4'b0101;
    logic [`ASIZE-1:0] init_sa = 13'h0400, ref_sa = 13'h1aaa, wr_sa = 13'h0123, rd_sa = 13'h0456;
    logic [`BSIZE-1:0] init_ba = 2'd1, ref_ba = 2'd2, wr_ba = 2'd3, rd_ba = 2'd0;
    logic [`ASIZE-1:0] Sa;
    logic [`BSIZE-1:0] Ba;
    int cyc = 0, n_chk = 0, n_fail = 0, t0 = 0;
    logic p_ref = 1'b0, p_wr = 1'b0, p_rd = 1'b0;
    exp_t q[$];

    sdram_cmd_arbiter #(.REF_PERIOD(100)) dut (
        .Clk(Clk), .Rst(Rst), .init_done(init_done), .wr_req(wr_req), .rd_req(rd_req),
        .write_en(write_en), .read_en(read_en), .ref_en(ref_en),
        .Wdata_done(Wdata_done), .Rdata_done(Rdata_done), .Ref_done(Ref_done),
        .init_cmd(init_cmd), .ref_cmd(ref_cmd), .wr_cmd(wr_cmd), .rd_cmd(rd_cmd),
        .init_sa(init_sa), .ref_sa(ref_sa), .wr_sa(wr_sa), .rd_sa(rd_sa),
        .init_ba(init_ba), .ref_ba(ref_ba), .wr_ba(wr_ba), .rd_ba(rd_ba),
        .Cs_n(Cs_n), .Ras_n(Ras_n), .Cas_n(Cas_n), .We_n(We_n), .Sa(Sa), .Ba(Ba),
        .ref_overrun(ref_overrun)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] pins_of(input int k);
        case (k)
            K_REF:   return {13'd0, 4'b0001, 13'h1aaa, 2'd2};
            K_WR:    return {13'd0, 4'b0100, 13'h0123, 2'd3};
            K_RD:    return {13'd0, 4'b0101, 13'h0456, 2'd0};
            K_INIT:  return {13'd0, 4'b0010, 13'h0400, 2'd1};
            default: return {13'd0, 4'b0111, 13'h0000, 2'd0};
        endcase
    endfunction

    function automatic logic [31:0] pins_now();
        return {13'd0, Cs_n, Ras_n, Cas_n, We_n, Sa, Ba};
    endfunction

    function automatic void expect_grant(input int kind, input int at);
        exp_t e;
        e.kind = kind;
        e.at   = at;
        q.push_back(e);
    endfunction

    // monitor: pops the scoreboard on every rising enable
    always @(negedge Clk) begin
        int k;
        exp_t e;
        chk("enables_onehot", 32'($countones({ref_en, write_en, read_en}) <= 1), 1);
        k = (ref_en && !p_ref) ? K_REF : (write_en && !p_wr) ? K_WR : (read_en && !p_rd) ? K_RD : -1;
        if (k >= 0) begin
            if (q.size() == 0) chk("unexpected_grant", k, 32'hffff_ffff);
            else begin
                e = q.pop_front();
                chk("grant_kind", k, e.kind);
                if (e.at >= 0) chk("grant_cycle", cyc, e.at);
                chk("grant_pins", pins_now(), pins_of(k));
            end
        end
        p_ref <= ref_en;
        p_wr  <= write_en;
        p_rd  <= read_en;
    end

    task automatic wait_any(output int k);
        int n = 0;
        while (!(ref_en || write_en || read_en) && n < 400) begin
            @(negedge Clk);
            n++;
        end
        k = ref_en ? K_REF : write_en ? K_WR : read_en ? K_RD : -1;
        if (k < 0) chk("grant_timeout", 0, 1);
    endtask

    task automatic serve_any(input int hold);
        int k;
        wait_any(k);
        if (k < 0) return;
        repeat (hold) @(posedge Clk);
        #1;
        Ref_done = (k == K_REF);
        Wdata_done = (k == K_WR);
        Rdata_done = (k == K_RD);
        @(posedge Clk);
        #1;
        {Ref_done, Wdata_done, Rdata_done} = 3'b000;
    endtask

    initial begin
        int k;
        int kinds[4];
`ifdef ARB_RR_EN
        kinds = '{K_WR, K_RD, K_WR, K_RD};
`else
        kinds = '{K_WR, K_WR, K_WR, K_WR};
`endif
        repeat (3) @(posedge Clk);
        #1;
        chk("rst_state", 32'(dut.r_state), 0);
        chk("rst_enables", {29'd0, ref_en, write_en, read_en}, 0);
        chk("rst_pins_init", pins_now(), pins_of(K_INIT));
        chk("rst_ref_cnt", 32'(dut.r_cnt), 0);
        Rst = 1'b0;
        repeat (5) @(posedge Clk);
        #1;
        chk("init_wait_state", 32'(dut.r_state), 0);
        chk("init_wait_cnt", 32'(dut.r_cnt), 0);
        chk("init_wait_pins", pins_now(), pins_of(K_INIT));
        init_done = 1'b1;
        t0 = cyc + 1;
        expect_grant(K_REF, t0 + 100);
        expect_grant(K_REF, t0 + 200);
        @(posedge Clk);
        #1;
        chk("idle_state", 32'(dut.r_state), 1);
        chk("idle_pins_nop", pins_now(), pins_of(-1));
        repeat (10) @(posedge Clk);
        #1;
        chk("ref_cnt_run", 32'(dut.r_cnt), 11);
        serve_any(1);
        chk("ref_en_low_after_done", 32'(ref_en), 0);
        Wdata_done = 1'b1;
        Rdata_done = 1'b1;
        @(posedge Clk);
        #1;
        {Wdata_done, Rdata_done} = 2'b00;
        chk("stray_done_idle", 32'(dut.r_state), 1);
        serve_any(1);
        wr_req = 1'b1;
        rd_req = 1'b1;
        foreach (kinds[i]) expect_grant(kinds[i], -1);
        expect_grant(K_REF, t0 + 300);
        for (int i = 0; i < 4; i++) serve_any(1);
        wr_req = 1'b0;
        rd_req = 1'b0;
        serve_any(1);
        chk("no_overrun_yet", 32'(ref_overrun), 0);
        wr_req = 1'b1;
        expect_grant(K_WR, t0 + 303);
        wait_any(k);
        @(posedge Clk);
        #1;
        wr_req = 1'b0;
        repeat (150) @(posedge Clk);
        #1;
        chk("write_held_1", {30'd0, write_en, ref_en}, 2);
        chk("one_expiry_no_overrun", 32'(ref_overrun), 0);
        repeat (60) @(posedge Clk);
        #1;
        chk("write_held_2", {30'd0, write_en, ref_en}, 2);
        chk("overrun_set", 32'(ref_overrun), 1);
        expect_grant(K_REF, -1);
        expect_grant(K_RD, -1);
        expect_grant(K_RD, -1);
        repeat (40) @(posedge Clk);
        #1;
        Wdata_done = 1'b1;
        rd_req = 1'b1;
        @(posedge Clk);
        #1;
        Wdata_done = 1'b0;
        serve_any(1);
        chk("overrun_sticky", 32'(ref_overrun), 1);
        serve_any(1);
        wait_any(k);
        @(posedge Clk);
        #1;
        Rst = 1'b1;
        rd_req = 1'b0;
        init_done = 1'b0;
        @(posedge Clk);
        #1;
        chk("midread_rst_read_en", 32'(read_en), 0);
        chk("midread_rst_state", 32'(dut.r_state), 0);
        chk("midread_rst_overrun", 32'(ref_overrun), 0);
        chk("midread_rst_pins", pins_now(), pins_of(K_INIT));
        Rst = 1'b0;
        Rdata_done = 1'b1;
        @(posedge Clk);
        #1;
        Rdata_done = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        chk("stray_rdone_state", 32'(dut.r_state), 0);
        chk("stray_rdone_read_en", 32'(read_en), 0);
        chk("post_rst_cnt", 32'(dut.r_cnt), 0);
        chk("queue_empty", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/sdram_cmd_arbiter.md
SDRAM_CMD_ARBITER -- requirements
Module: sdram_cmd_arbiter

Interface
REQ-001 SHALL have parameter REF_PERIOD, default 781, auto-refresh interval in Clk cycles (7.8 us at 100 MHz); legal range 16..65535.
REQ-002 SHALL have port Clk  in  1  single system clock; all logic on rising edge.
REQ-003 SHALL have port Rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port init_done  in  1  SDRAM power-up init sequence complete (level).
REQ-005 SHALL have ports wr_req / rd_req  in  1 each  user burst write / read request (level).
REQ-006 SHALL have ports write_en / read_en / ref_en  out  1 each  run-enable to the write / read / refresh sequencers, held high for the whole operation.
REQ-007 SHALL have ports Wdata_done / Rdata_done / Ref_done  in  1 each  one-cycle completion pulse from each sequencer.
REQ-008 SHALL have ports init_cmd, ref_cmd, wr_cmd, rd_cmd  in  4 each  {Cs_n,Ras_n,Cas_n,We_n} from each sequencer.
REQ-009 SHALL have ports init_sa/ref_sa/wr_sa/rd_sa  in  `ASIZE  and init_ba/ref_ba/wr_ba/rd_ba  in  `BSIZE  address/bank from each sequencer.
REQ-010 SHALL have ports Cs_n, Ras_n, Cas_n, We_n  out  1 each, Sa  out  `ASIZE, Ba  out  `BSIZE  SDRAM pins.
REQ-011 SHALL have port ref_overrun  out  1  sticky flag: a refresh interval expired while a refresh was still pending.

Function
REQ-012 SHALL implement registered states S_INIT, S_IDLE, S_AREF, S_WRITE, S_READ.
REQ-013 S_INIT SHALL go to S_IDLE on the edge where init_done=1.
REQ-014 In S_IDLE, priority SHALL be: ref_pending -> S_AREF; else write/read grant per REQ-025 -> S_WRITE / S_READ; else stay.
REQ-015 S_AREF / S_WRITE / S_READ SHALL return to S_IDLE on the edge where Ref_done / Wdata_done / Rdata_done=1; at least one S_IDLE cycle separates grants.
REQ-016 ref_en / write_en / read_en SHALL equal 1 exactly while in S_AREF / S_WRITE / S_READ (decoded from the state register, no extra latency); at most one is high at once.
REQ-017 Done pulses arriving outside their own state SHALL be ignored; deassertion of wr_req/rd_req during a burst SHALL NOT abort it.
REQ-018 Refresh counter SHALL be held at 0 until init_done has been seen, then count 0..REF_PERIOD-1 and wrap; at count REF_PERIOD-1 ref_pending SHALL be set.
REQ-019 ref_pending SHALL clear on entry to S_AREF; if expiry coincides with that entry, set SHALL win.
REQ-020 Refresh SHALL NOT preempt a burst in progress; the counter keeps running during bursts.
REQ-021 Expiry while ref_pending already 1 SHALL set ref_overrun, which holds until Rst.
REQ-022 Pin mux SHALL be combinational on state: S_INIT -> init bus; S_AREF -> ref bus; S_WRITE -> wr bus; S_READ -> rd bus; S_IDLE -> NOP (4'b0111), Sa=0, Ba=0.

Reset
REQ-023 On Rst=1 at a rising edge: state=S_INIT, write_en=read_en=ref_en=0, refresh counter=0, ref_pending=0, ref_overrun=0, last-grant register=read; applies mid-burst with enables low from that edge.
REQ-024 While in S_INIT after reset, pins SHALL carry the init bus.

Configuration
REQ-025 Macro ARB_RR_EN defined: when wr_req and rd_req are both 1 in S_IDLE with no refresh pending, the requester not granted last SHALL win (write first after reset), and the last-grant register updates on each grant; undefined: write SHALL always win over read and the last-grant register SHALL not exist.

Verification
REQ-026 Rst 1 for 3 cycles, init_done=0 -> state S_INIT, all enables 0, pins equal init bus, ref counter stays 0.
REQ-027 REF_PERIOD=100, init_done=1, no requests -> ref_en rises 100 cycles after S_IDLE entry, Ref_done pulse -> ref_en low next cycle, repeats every 100 cycles.
REQ-028 wr_req=1 and rd_req=1 held constantly, refresh idle -> ARB_RR_EN: grants alternate W,R,W,R; without: only W.
REQ-029 Burst WRITE with Wdata_done withheld 250 cycles, REF_PERIOD=100 -> no preemption, ref_overrun=1 after second expiry, refresh granted first after Wdata_done.
REQ-030 Rst asserted in S_READ -> next edge read_en=0, state S_INIT, ref_overrun cleared; stray Rdata_done afterwards ignored.
